// File: rtl/sobel_stream.sv
// sobel_stream: streaming 3x3 Sobel edge-magnitude filter between two show-ahead FIFOs.
// Optional binarisation against the threshold input is enabled by defining SOBEL_THRESHOLD_EN.
module sobel_stream #(
    parameter int IMG_WIDTH   = 720,
    parameter int IMG_HEIGHT  = 540,
    parameter int PIXEL_WIDTH = 8,
    parameter int MAG_MODE    = 0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_empty,
    output logic                   in_rd_en,
    input  logic [PIXEL_WIDTH-1:0] in_din,
    input  logic                   out_full,
    output logic                   out_wr_en,
    output logic [PIXEL_WIDTH-1:0] out_din,
    output logic                   frame_done,
    input  logic [PIXEL_WIDTH-1:0] threshold
);
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam int GW = PIXEL_WIDTH + 3;
    localparam logic [1:0] S_FILL  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    logic [1:0]             state_reg;
    logic                   active_reg, valid_reg, last_reg;
    logic [CW-1:0]          col_reg, ccol_reg, col_next, rd_addr;
    logic [RW-1:0]          row_reg, crow_reg;
    logic [PIXEL_WIDTH-1:0] dout_reg;
    logic [PIXEL_WIDTH-1:0] lb1 [IMG_WIDTH];
    logic [PIXEL_WIDTH-1:0] lb2 [IMG_WIDTH];
    logic [PIXEL_WIDTH-1:0] lb1_rd_reg, lb2_rd_reg;
    logic [PIXEL_WIDTH-1:0] tap_reg [3][2];
    logic [PIXEL_WIDTH-1:0] win [3][3];
    logic [PIXEL_WIDTH-1:0] new_col [3];
    logic                   can_accept, step, produce, flushing;
    logic                   col_last, row_last, centre_last, border;

    assign out_wr_en  = valid_reg & ~out_full;
    assign can_accept = ~valid_reg | out_wr_en;
    assign flushing   = (state_reg == S_FLUSH);
    // Every step, fill included, waits on the output register so backpressure freezes the whole pipe.
    assign step       = active_reg & can_accept & (flushing | ~in_empty);
    assign in_rd_en   = step & ~flushing;
    assign produce    = step & (state_reg != S_FILL);
    assign frame_done = out_wr_en & last_reg;
    assign out_din    = dout_reg;

    assign col_last    = (col_reg == COL_LAST);
    assign row_last    = (row_reg == ROW_LAST);
    assign col_next    = col_last ? '0 : col_reg + CW'(1);
    assign rd_addr     = in_rd_en ? col_next : col_reg;
    assign centre_last = (crow_reg == ROW_LAST) && (ccol_reg == COL_LAST);
    assign border      = (crow_reg == '0) || (crow_reg == ROW_LAST) ||
                         (ccol_reg == '0) || (ccol_reg == COL_LAST);

    // The window is the two registered columns plus the column arriving in this step.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_win_row
            assign new_col[gi] = flushing ? '0 :
                                 (gi == 0) ? lb2_rd_reg :
                                 (gi == 1) ? lb1_rd_reg : in_din;
            assign win[gi][0]  = tap_reg[gi][0];
            assign win[gi][1]  = tap_reg[gi][1];
            assign win[gi][2]  = new_col[gi];
        end
    endgenerate

    logic [GW-1:0]          gx_pos, gx_neg, gy_pos, gy_neg;
    logic signed [GW-1:0]   gx, gy;
    logic [GW-2:0]          ax, ay, mag_wide;
    logic [PIXEL_WIDTH-1:0] mag_sat, pix_val;

    assign gx_pos = GW'(win[0][2]) + (GW'(win[1][2]) << 1) + GW'(win[2][2]);
    assign gx_neg = GW'(win[0][0]) + (GW'(win[1][0]) << 1) + GW'(win[2][0]);
    assign gy_pos = GW'(win[2][0]) + (GW'(win[2][1]) << 1) + GW'(win[2][2]);
    assign gy_neg = GW'(win[0][0]) + (GW'(win[0][1]) << 1) + GW'(win[0][2]);
    assign gx     = $signed(gx_pos - gx_neg);
    assign gy     = $signed(gy_pos - gy_neg);
    assign ax     = gx[GW-1] ? (GW-1)'(-gx) : (GW-1)'(gx);
    assign ay     = gy[GW-1] ? (GW-1)'(-gy) : (GW-1)'(gy);

    generate
        if (MAG_MODE == 0) begin : g_mag_sum
            assign mag_wide = (GW-1)'((GW'(ax) + GW'(ay)) >> 1);
        end else begin : g_mag_max
            assign mag_wide = (ax > ay) ? ax : ay;
        end
    endgenerate

    assign mag_sat = (|mag_wide[GW-2:PIXEL_WIDTH]) ? '1 : mag_wide[PIXEL_WIDTH-1:0];

`ifdef SOBEL_THRESHOLD_EN
    assign pix_val = (mag_sat >= threshold) ? '1 : '0;
`else
    logic threshold_unused;
    assign threshold_unused = ^threshold;
    assign pix_val = mag_sat;
`endif

    // Line buffers with registered read; the read address runs one column ahead during a read step.
    always_ff @(posedge clock) begin
        if (in_rd_en) begin
            lb1[col_reg] <= in_din;
            lb2[col_reg] <= lb1_rd_reg;
        end
        lb1_rd_reg <= lb1[rd_addr];
        lb2_rd_reg <= lb2[rd_addr];
        if (step) begin
            for (int r = 0; r < 3; r++) begin
                tap_reg[r][0] <= tap_reg[r][1];
                tap_reg[r][1] <= new_col[r];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg  <= S_FILL;
            active_reg <= 1'b0;
            valid_reg  <= 1'b0;
            last_reg   <= 1'b0;
            dout_reg   <= '0;
            col_reg    <= '0;
            row_reg    <= '0;
            ccol_reg   <= '0;
            crow_reg   <= '0;
        end else begin
            active_reg <= 1'b1;
            if (in_rd_en) begin
                col_reg <= col_next;
                if (col_last) row_reg <= row_last ? '0 : row_reg + RW'(1);
            end
            if (produce) begin
                valid_reg <= 1'b1;
                dout_reg  <= border ? '0 : pix_val;
                last_reg  <= centre_last;
                ccol_reg  <= (ccol_reg == COL_LAST) ? '0 : ccol_reg + CW'(1);
                if (ccol_reg == COL_LAST)
                    crow_reg <= (crow_reg == ROW_LAST) ? '0 : crow_reg + RW'(1);
            end else if (out_wr_en) begin
                valid_reg <= 1'b0;
            end
            if (step) begin
                case (state_reg)
                    S_FILL:  if (row_reg == RW'(1) && col_reg == '0) state_reg <= S_RUN;
                    S_RUN:   if (row_last && col_last) state_reg <= S_FLUSH;
                    S_FLUSH: if (centre_last) state_reg <= S_FILL;
                    default: state_reg <= S_FILL;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_sobel_stream.sv
// Self-checking bench for sobel_stream: two instances (sum and max magnitude) against an image-level model.
module tb_sobel_stream;
    localparam int W    = 8;
    localparam int H    = 4;
    localparam int N    = W * H;
    localparam int MAXV = 255;
    localparam int BUDGET = 3000;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       in_empty = 1'b1;
    logic       out_full = 1'b0;
    logic [7:0] in_din = '0;
    logic [7:0] threshold = 8'd30;
    logic       rd0, wr0, done0, rd1, wr1, done1;
    logic [7:0] dout0, dout1;

    int pass_cnt = 0;
    int total_cnt = 0;
    int src_q[$];
    int exp0[$];
    int exp1[$];
    int got0[$];
    int got1[$];
    int done_idx0[$];
    int done_cnt1;
    int rd_cnt;
    int img [H][W];

    always #5 clock = ~clock;

    sobel_stream #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIXEL_WIDTH(8), .MAG_MODE(0)) u_dut0 (
        .clock(clock), .reset(reset), .in_empty(in_empty), .in_rd_en(rd0), .in_din(in_din),
        .out_full(out_full), .out_wr_en(wr0), .out_din(dout0), .frame_done(done0),
        .threshold(threshold));

    sobel_stream #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIXEL_WIDTH(8), .MAG_MODE(1)) u_dut1 (
        .clock(clock), .reset(reset), .in_empty(in_empty), .in_rd_en(rd1), .in_din(in_din),
        .out_full(out_full), .out_wr_en(wr1), .out_din(dout1), .frame_done(done1),
        .threshold(threshold));

    // Golden value of output pixel (r,c) of the image in img, straight from the Sobel definition.
    function automatic int model_pix(input int r, input int c, input int mode);
        int gx, gy, ax, ay, m;
        if (r == 0 || r == H - 1 || c == 0 || c == W - 1) return 0;
        gx = (img[r-1][c+1] + 2 * img[r][c+1] + img[r+1][c+1])
           - (img[r-1][c-1] + 2 * img[r][c-1] + img[r+1][c-1]);
        gy = (img[r+1][c-1] + 2 * img[r+1][c] + img[r+1][c+1])
           - (img[r-1][c-1] + 2 * img[r-1][c] + img[r-1][c+1]);
        ax = (gx < 0) ? -gx : gx;
        ay = (gy < 0) ? -gy : gy;
        m  = (mode == 0) ? (ax + ay) / 2 : ((ax > ay) ? ax : ay);
        if (m > MAXV) m = MAXV;
`ifdef SOBEL_THRESHOLD_EN
        m = (m >= int'(threshold)) ? MAXV : 0;
`endif
        return m;
    endfunction

    // kind 0: uniform v, 1: vertical step of height v at column W/2, other: random
    task automatic make_frame(input int kind, input int v);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = (kind == 0) ? v : (kind == 1) ? ((c >= W / 2) ? v : 0)
                                                          : int'($urandom_range(255));
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                src_q.push_back(img[r][c]);
                exp0.push_back(model_pix(r, c, 0));
                exp1.push_back(model_pix(r, c, 1));
            end
    endtask

    task automatic clear_all();
        src_q.delete(); exp0.delete(); exp1.delete();
        got0.delete(); got1.delete(); done_idx0.delete();
        done_cnt1 = 0;
        rd_cnt = 0;
    endtask

    // One cycle: drive the FIFO models at the falling edge, sample strobes 1 ns later.
    task automatic tick(input int gap_pct, input int full_pct);
        @(negedge clock);
        in_empty = (src_q.size() == 0) || (int'($urandom_range(99)) < gap_pct);
        in_din   = (src_q.size() != 0) ? 8'(src_q[0]) : 8'd0;
        out_full = (int'($urandom_range(99)) < full_pct);
        #1;
        if (rd0) begin
            void'(src_q.pop_front());
            rd_cnt++;
        end
        if (wr0) begin
            got0.push_back(int'(dout0));
            if (done0) done_idx0.push_back(got0.size() - 1);
        end
        if (wr1) begin
            got1.push_back(int'(dout1));
            if (done1) done_cnt1++;
        end
    endtask

    task automatic run_stream(input int gap_pct, input int full_pct, output bit timed_out);
        int cyc = 0;
        while ((got0.size() < exp0.size() || got1.size() < exp1.size()) && cyc < BUDGET) begin
            tick(gap_pct, full_pct);
            cyc++;
        end
        timed_out = (cyc >= BUDGET);
        repeat (12) tick(0, 0);
    endtask

    task automatic test_reset;
        in_empty = 1'b0;
        out_full = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        total_cnt++;
        if (rd0 !== 1'b0) $display("FAIL reset_rd_en: got %0b expected 0", rd0); else pass_cnt++;
        total_cnt++;
        if (wr0 !== 1'b0) $display("FAIL reset_wr_en: got %0b expected 0", wr0); else pass_cnt++;
        total_cnt++;
        if (dout0 !== 8'd0) $display("FAIL reset_out_din: got %0d expected 0", dout0); else pass_cnt++;
        total_cnt++;
        if (done0 !== 1'b0) $display("FAIL reset_frame_done: got %0b expected 0", done0); else pass_cnt++;
        @(negedge clock);
        in_empty = 1'b1;
        reset = 1'b1;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_uniform;
        bit to;
        clear_all();
        make_frame(0, 100);
        run_stream(0, 0, to);
        total_cnt++;
        if (to) $display("FAIL uniform_timeout: got %0d writes expected %0d", got0.size(), N); else pass_cnt++;
        total_cnt++;
        if (got0.size() !== N) $display("FAIL uniform_count: got %0d expected %0d", got0.size(), N); else pass_cnt++;
        for (int i = 0; i < N; i++) begin
            int g;
            g = (i < got0.size()) ? got0[i] : -1;
            total_cnt++;
            if (g !== exp0[i]) $display("FAIL uniform_pix[%0d]: got %0d expected %0d", i, g, exp0[i]);
            else pass_cnt++;
        end
        total_cnt++;
        if (done_idx0.size() !== 1) $display("FAIL uniform_done_count: got %0d expected 1", done_idx0.size());
        else pass_cnt++;
        total_cnt++;
        if (done_idx0.size() == 0 || done_idx0[0] !== N - 1)
            $display("FAIL uniform_done_pos: got %0d expected %0d", (done_idx0.size() != 0) ? done_idx0[0] : -1, N - 1);
        else pass_cnt++;
    endtask

    task automatic test_step(input int height);
        bit to;
        clear_all();
        make_frame(1, height);
        run_stream(0, 0, to);
        total_cnt++;
        if (to) $display("FAIL step%0d_timeout: got %0d writes expected %0d", height, got0.size(), N); else pass_cnt++;
        total_cnt++;
        if (got0.size() !== N || got1.size() !== N)
            $display("FAIL step%0d_count: got %0d/%0d expected %0d", height, got0.size(), got1.size(), N);
        else pass_cnt++;
        for (int i = 0; i < N; i++) begin
            int g0, g1;
            g0 = (i < got0.size()) ? got0[i] : -1;
            g1 = (i < got1.size()) ? got1[i] : -1;
            total_cnt++;
            if (g0 !== exp0[i]) $display("FAIL step%0d_sum[%0d]: got %0d expected %0d", height, i, g0, exp0[i]);
            else pass_cnt++;
            total_cnt++;
            if (g1 !== exp1[i]) $display("FAIL step%0d_max[%0d]: got %0d expected %0d", height, i, g1, exp1[i]);
            else pass_cnt++;
        end
        total_cnt++;
        if (done_cnt1 !== 1) $display("FAIL step%0d_done_max: got %0d expected 1", height, done_cnt1); else pass_cnt++;
    endtask

    task automatic test_random_traffic;
        bit to;
        clear_all();
        repeat (3) make_frame(2, 0);
        run_stream(25, 25, to);
        total_cnt++;
        if (to) $display("FAIL random_timeout: got %0d writes expected %0d", got0.size(), 3 * N); else pass_cnt++;
        total_cnt++;
        if (got0.size() !== 3 * N || got1.size() !== 3 * N)
            $display("FAIL random_count: got %0d/%0d expected %0d", got0.size(), got1.size(), 3 * N);
        else pass_cnt++;
        for (int i = 0; i < 3 * N; i++) begin
            int g0, g1;
            g0 = (i < got0.size()) ? got0[i] : -1;
            g1 = (i < got1.size()) ? got1[i] : -1;
            total_cnt++;
            if (g0 !== exp0[i] || g1 !== exp1[i])
                $display("FAIL random_pix[%0d]: got %0d/%0d expected %0d/%0d", i, g0, g1, exp0[i], exp1[i]);
            else pass_cnt++;
        end
        for (int k = 0; k < 3; k++) begin
            int g;
            g = (k < done_idx0.size()) ? done_idx0[k] : -1;
            total_cnt++;
            if (g !== (k + 1) * N - 1) $display("FAIL random_done[%0d]: got %0d expected %0d", k, g, (k + 1) * N - 1);
            else pass_cnt++;
        end
    endtask

    task automatic test_backpressure;
        bit to;
        int cyc = 0;
        clear_all();
        make_frame(2, 0);
        while (got0.size() < 12 && cyc < 500) begin
            tick(0, 0);
            cyc++;
        end
        for (int i = 0; i < 50; i++) begin
            tick(0, 100);
            total_cnt++;
            if (wr0 !== 1'b0 || wr1 !== 1'b0)
                $display("FAIL bp_wr_en[%0d]: got %0b/%0b expected 0", i, wr0, wr1);
            else pass_cnt++;
            if (i > 0) begin
                total_cnt++;
                if (rd0 !== 1'b0 || rd1 !== 1'b0)
                    $display("FAIL bp_rd_en[%0d]: got %0b/%0b expected 0", i, rd0, rd1);
                else pass_cnt++;
            end
        end
        run_stream(0, 0, to);
        total_cnt++;
        if (to) $display("FAIL bp_timeout: got %0d writes expected %0d", got0.size(), N); else pass_cnt++;
        total_cnt++;
        if (got0.size() !== N || got1.size() !== N)
            $display("FAIL bp_count: got %0d/%0d expected %0d", got0.size(), got1.size(), N);
        else pass_cnt++;
        for (int i = 0; i < N; i++) begin
            int g0, g1;
            g0 = (i < got0.size()) ? got0[i] : -1;
            g1 = (i < got1.size()) ? got1[i] : -1;
            total_cnt++;
            if (g0 !== exp0[i] || g1 !== exp1[i])
                $display("FAIL bp_pix[%0d]: got %0d/%0d expected %0d/%0d", i, g0, g1, exp0[i], exp1[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid;
        bit to;
        int cyc = 0;
        clear_all();
        make_frame(2, 0);
        while (rd_cnt < 13 && cyc < 500) begin
            tick(0, 0);
            cyc++;
        end
        @(posedge clock);
        #2;
        reset = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        total_cnt++;
        if (rd0 !== 1'b0 || wr0 !== 1'b0 || done0 !== 1'b0)
            $display("FAIL midreset_outputs: got rd=%0b wr=%0b done=%0b expected 0", rd0, wr0, done0);
        else pass_cnt++;
        clear_all();
        @(negedge clock);
        reset = 1'b1;
        make_frame(2, 0);
        make_frame(2, 0);
        run_stream(10, 10, to);
        total_cnt++;
        if (to) $display("FAIL midreset_timeout: got %0d writes expected %0d", got0.size(), 2 * N); else pass_cnt++;
        total_cnt++;
        if (got0.size() !== 2 * N) $display("FAIL midreset_count: got %0d expected %0d", got0.size(), 2 * N);
        else pass_cnt++;
        for (int i = 0; i < 2 * N; i++) begin
            int g0, g1;
            g0 = (i < got0.size()) ? got0[i] : -1;
            g1 = (i < got1.size()) ? got1[i] : -1;
            total_cnt++;
            if (g0 !== exp0[i] || g1 !== exp1[i])
                $display("FAIL midreset_pix[%0d]: got %0d/%0d expected %0d/%0d", i, g0, g1, exp0[i], exp1[i]);
            else pass_cnt++;
        end
        total_cnt++;
        if (done_idx0.size() !== 2 || done_cnt1 !== 2)
            $display("FAIL midreset_done_count: got %0d/%0d expected 2", done_idx0.size(), done_cnt1);
        else pass_cnt++;
        for (int k = 0; k < 2; k++) begin
            int g;
            g = (k < done_idx0.size()) ? done_idx0[k] : -1;
            total_cnt++;
            if (g !== (k + 1) * N - 1) $display("FAIL midreset_done[%0d]: got %0d expected %0d", k, g, (k + 1) * N - 1);
            else pass_cnt++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_uniform();
        test_step(20);
        test_step(255);
`ifdef SOBEL_THRESHOLD_EN
        threshold = 8'd41;
        test_step(20);
        threshold = 8'd30;
`endif
        test_random_traffic();
        test_backpressure();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/sobel_stream.md
Name: sobel_stream

Overview:
- Parametrised streaming 3x3 Sobel edge filter for the edge_detect pipeline, placed between the grayscale stage and the output FIFO.
- Reads raster-order grayscale pixels from an upstream FIFO and writes exactly one magnitude pixel per input pixel to a downstream FIFO.
- Generalises the fixed 720x540, 8-bit Sobel stage to arbitrary image size, pixel width and magnitude mode.
- Supports back-to-back frames, border zeroing and end-of-frame flush.

Parameters:
- IMG_WIDTH, 720, pixels per row; must be >= 3.
- IMG_HEIGHT, 540, rows per frame; must be >= 3.
- PIXEL_WIDTH, 8, bits per grayscale pixel, for both input and output.
- MAG_MODE, 0, magnitude select: 0 = (|gx|+|gy|)>>1; 1 = max(|gx|,|gy|). Both results are clamped to 2^PIXEL_WIDTH-1.

Ports:
- clock      in   1              system clock; all state changes on the rising edge.
- reset      in   1              asynchronous, active-low reset.
- in_empty   in   1              upstream FIFO empty.
- in_rd_en   out  1              upstream FIFO read strobe; in_din is valid in the same cycle (show-ahead FIFO).
- in_din     in   PIXEL_WIDTH    input grayscale pixel.
- out_full   in   1              downstream FIFO full.
- out_wr_en  out  1              downstream FIFO write strobe.
- out_din    out  PIXEL_WIDTH    output edge magnitude.
- frame_done out  1              one-cycle pulse when the last pixel of a frame is written.
- threshold  in   PIXEL_WIDTH    binarisation level; used only when SOBEL_THRESHOLD_EN is defined, ignored otherwise.

Behaviour:
- Reset (reset=0, asynchronous)
  - in_rd_en=0, out_wr_en=0, out_din=0, frame_done=0.
  - state=S_FILL; all column/row counters and the output-valid flag cleared.
  - Line-buffer contents need not be cleared.
  - A reset mid-frame discards the partial frame; the first pixel read after reset is pixel (0,0) of a new frame.
- Storage
  - Two line buffers of IMG_WIDTH x PIXEL_WIDTH (rows r-1 and r-2) plus a 3x3 window register.
  - The window shifts one column per step.
- Output register
  - One output register with a valid flag.
  - out_wr_en = valid & !out_full (combinational).
  - A pipeline step may occur only when (!valid | out_wr_en), so a result is never lost or overwritten.
- States
  - S_FILL: step when !in_empty. in_rd_en=1, no result produced. After IMG_WIDTH+1 reads, go to S_RUN.
  - S_RUN: step when !in_empty and the output register can accept. in_rd_en=1 and a result is loaded for the centre pixel (input index n-(IMG_WIDTH+1)). After input index IMG_WIDTH*IMG_HEIGHT-1 is consumed, go to S_FLUSH.
  - S_FLUSH: step when the output register can accept, with in_rd_en=0 and zeros shifted in. After IMG_WIDTH+1 results, go to S_FILL for the next frame.
- Latency
  - First output result is registered 1 cycle after the step that reads pixel (1,1).
  - Minimum read-to-write latency in S_RUN is 1 cycle.
  - Throughput is 1 pixel/cycle with no stalls.
- Arithmetic
  - gx = (p02 + 2*p12 + p22) - (p00 + 2*p10 + p20), where pRC denotes window row R, column C, with the centre at p11.
  - gy = (p20 + 2*p21 + p22) - (p00 + 2*p01 + p02).
  - gx and gy are signed, PIXEL_WIDTH+3 bits wide. The magnitude is computed per MAG_MODE and saturated to 2^PIXEL_WIDTH-1.
- Borders
  - Output centre pixels in row 0, row IMG_HEIGHT-1, column 0 or column IMG_WIDTH-1 produce 0.
  - Windows that straddle a row wrap are never used for a non-border output.
- Frame accounting
  - Exactly IMG_WIDTH*IMG_HEIGHT writes per frame.
  - frame_done pulses in the cycle of the final out_wr_en of the frame.
  - The next frame's S_FILL reads may begin in the cycle after the last flush step.
- Simultaneous events
  - out_full rising while valid=1: hold out_din and valid; freeze all steps.
  - in_empty in S_RUN: hold state; out_wr_en may still drain the pending result.

Optional Feature:
- Macro: SOBEL_THRESHOLD_EN.
- Defined: the saturated magnitude m becomes out_din = (m >= threshold) ? 2^PIXEL_WIDTH-1 : 0. threshold is sampled in the same step as the result. Borders still output 0.
- Undefined: out_din = m. The threshold port is present but ignored, and no compare logic is synthesised.

Test Plan:
- Uniform frame: IMG_WIDTH=8, IMG_HEIGHT=4, all pixels 100 -> 32 writes, all 0; frame_done pulses once, on the 32nd write.
- Vertical step, MAG_MODE=0: 8x4 frame, cols 0-3 = 0, cols 4-7 = 20 -> rows 1-2, cols 3 and 4 = 40; all other pixels 0.
- Same step, MAG_MODE=1 -> those four pixels = 80. Step height 255 -> 255 in both modes (clamp of 1020).
- Backpressure: hold out_full=1 for 50 cycles mid-frame -> out_wr_en=0 and in_rd_en stalls within 1 cycle; no pixel lost or duplicated; output matches the golden model.
- Reset mid-frame: assert reset after 13 reads, then stream two full frames back-to-back -> both frames match the golden model, with exactly 64 writes and 2 frame_done pulses.
- With SOBEL_THRESHOLD_EN, threshold=30, the 20-step frame, MAG_MODE=0 -> cols 3/4 in rows 1-2 = 255, all others 0. With threshold=41 -> all 0.
